// File: rtl/alu_dispatch.sv
// alu_dispatch: issue-side front end of the ALU.
// Accepts one op per cycle, decodes it to a one-hot unit start, keeps a small
// alignment pipeline so the result mux select lines up with unit latency,
// and queues the registered mux output in a credit-protected result FIFO.
module alu_dispatch #(
   parameter int WIDTH      = 16,
   parameter int UNIT_LAT   = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [2:0]       unit_en,
   output logic [3:0]       unit_op,
   output logic [WIDTH-1:0] unit_a,
   output logic [WIDTH-1:0] unit_b,
   output logic [2:0]       mux_en,
   input  logic [WIDTH-1:0] mux_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_err
);

   // Stages 0..UNIT_LAT line up with the units; the extra last stage is the
   // cycle in which the registered mux output is written into the FIFO.
   localparam int NSTG = UNIT_LAT + 2;
   localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW   = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic             in_ready_reg;
   logic             accept;
   logic [2:0]       dec_sel;
   logic             dec_err;

   logic [2:0]       unit_en_reg;
   logic [3:0]       unit_op_reg;
   logic [WIDTH-1:0] unit_a_reg;
   logic [WIDTH-1:0] unit_b_reg;

   logic [NSTG-1:0]  pv_reg;
   logic [NSTG-1:0]  perr_reg;
   logic [2:0]       psel_reg [UNIT_LAT+1];

   logic             fifo_wr;
   logic [WIDTH-1:0] fifo_wdata;
   logic             fifo_werr;
   logic             pop;
   logic [WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] mem_err;
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    fifo_count_reg;

   logic [CW-1:0]    outstanding_reg;
   logic [CW-1:0]    outstanding_next;

   assign accept = in_valid & in_ready_reg;

   // Opcode to one-hot unit select; anything above 8 is illegal and selects nothing.
   always_comb begin
      dec_sel = 3'b000;
      dec_err = 1'b0;
      case (in_op)
         4'd0, 4'd1:                   dec_sel = 3'b001;
         4'd2, 4'd3, 4'd4, 4'd5:       dec_sel = 3'b010;
         4'd6, 4'd7, 4'd8:             dec_sel = 3'b100;
         default:                      dec_err = 1'b1;
      endcase
   end

   // Issue register: start pulse for one cycle, operands held between accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unit_en_reg <= 3'b000;
         unit_op_reg <= 4'd0;
         unit_a_reg  <= '0;
         unit_b_reg  <= '0;
      end else begin
         unit_en_reg <= accept ? dec_sel : 3'b000;
         if (accept) begin
            unit_op_reg <= in_op;
            unit_a_reg  <= in_a;
            unit_b_reg  <= in_b;
         end
      end
   end

   assign unit_en = unit_en_reg;
   assign unit_op = unit_op_reg;
   assign unit_a  = unit_a_reg;
   assign unit_b  = unit_b_reg;

   // Alignment pipeline carrying {valid, sel, err} for every accepted op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv_reg   <= '0;
         perr_reg <= '0;
         for (int i = 0; i < UNIT_LAT + 1; i++) psel_reg[i] <= 3'b000;
      end else begin
         pv_reg      <= {pv_reg[NSTG-2:0], accept};
         perr_reg    <= {perr_reg[NSTG-2:0], accept & dec_err};
         psel_reg[0] <= accept ? dec_sel : 3'b000;
         for (int i = 1; i < UNIT_LAT + 1; i++) psel_reg[i] <= psel_reg[i-1];
      end
   end

   assign mux_en     = pv_reg[UNIT_LAT] ? psel_reg[UNIT_LAT] : 3'b000;
   assign fifo_wr    = pv_reg[NSTG-1];
   assign fifo_werr  = perr_reg[NSTG-1];
   assign fifo_wdata = fifo_werr ? '0 : mux_out;

   // Result storage; no reset needed since the head is gated by occupancy.
   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         mem_data[wr_ptr_reg] <= fifo_wdata;
         mem_err[wr_ptr_reg]  <= fifo_werr;
      end
   end

   assign res_valid = (fifo_count_reg != '0);
   assign pop       = res_valid & res_ready;
   assign res_data  = res_valid ? mem_data[rd_ptr_reg] : '0;
   assign res_err   = res_valid & mem_err[rd_ptr_reg];

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
      end else begin
         if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({fifo_wr, pop})
            2'b10:   fifo_count_reg <= fifo_count_reg + CW'(1);
            2'b01:   fifo_count_reg <= fifo_count_reg - CW'(1);
            default: fifo_count_reg <= fifo_count_reg;
         endcase
      end
   end

   // Credit count: in-flight ops plus FIFO occupancy.
   always_comb begin
      outstanding_next = outstanding_reg;
      if (accept && !pop)      outstanding_next = outstanding_reg + CW'(1);
      else if (!accept && pop) outstanding_next = outstanding_reg - CW'(1);
   end

   // Credits and ready are registered so ready never depends on same-cycle inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_reg <= '0;
         in_ready_reg    <= 1'b0;
      end else begin
         outstanding_reg <= outstanding_next;
         in_ready_reg    <= (outstanding_next < DEPTH_C);
      end
   end

   assign in_ready = in_ready_reg;

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: self-checking bench with behavioural unit/mux models and a
// queue scoreboard of expected results.
module tb_alu_dispatch;
   localparam int W = 16;
   localparam int L = 1;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   in_op = 4'd0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [2:0]   unit_en;
   logic [3:0]   unit_op;
   logic [W-1:0] unit_a;
   logic [W-1:0] unit_b;
   logic [2:0]   mux_en;
   logic [W-1:0] mux_out = '0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [W-1:0] res_data;
   logic         res_err;

   always #5 clk = ~clk;

   alu_dispatch #(.WIDTH(W), .UNIT_LAT(L), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .unit_en(unit_en), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
      .mux_en(mux_en), .mux_out(mux_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Arithmetic meaning of each opcode, as the units would compute it.
   function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int sh;
      sh = int'(b) % W;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return ~a;
         4'd6: return a << sh;
         4'd7: return a >> sh;
         4'd8: return W'($signed(a) >>> sh);
         default: return '0;
      endcase
   endfunction

   function automatic logic [2:0] unit_of(input logic [3:0] op);
      if (op <= 4'd1) return 3'b001;
      if (op <= 4'd5) return 3'b010;
      if (op <= 4'd8) return 3'b100;
      return 3'b000;
   endfunction

   // Unit model: result valid UNIT_LAT cycles after the start pulse.
   logic [2:0]   dl_en  [L];
   logic [W-1:0] dl_res [L];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < L; k++) begin
            dl_en[k]  <= 3'b000;
            dl_res[k] <= '0;
         end
      end else begin
         dl_en[0]  <= unit_en;
         dl_res[0] <= alu_ref(unit_op, unit_a, unit_b);
         for (int k = 1; k < L; k++) begin
            dl_en[k]  <= dl_en[k-1];
            dl_res[k] <= dl_res[k-1];
         end
      end
   end

   // Registered result mux model; garbage when nothing is selected.
   always @(posedge clk) begin
      mux_out <= (mux_en != 3'b000) ? dl_res[L-1] : W'($urandom);
   end

   typedef struct {
      logic [W-1:0] data;
      logic         err;
      int           cyc;
   } ent_t;

   ent_t         sb[$];
   logic [W:0]   popped[$];
   int           cyc = 0;
   int           n_acc = 0;
   bit           first = 1'b1;
   bit           chk_lat = 1'b0;
   bit           ld_prev = 1'b0;
   logic [2:0]   exp_en = 3'b000;
   logic [3:0]   exp_op = 4'd0;
   logic [W-1:0] exp_a = '0;
   logic [W-1:0] exp_b = '0;

   // Cycle monitor, sampled mid-cycle when everything is stable.
   always @(negedge clk) begin
      ent_t e;
      cyc++;
      if (!rst_n) begin
         sb.delete();
         exp_en  = 3'b000;
         ld_prev = 1'b0;
         first   = 1'b1;
      end else begin
         check("in_ready", in_ready, (sb.size() < D) && !first);
         first = 1'b0;
         check("unit_en", unit_en, exp_en);
         if (ld_prev) begin
            check("unit_op", unit_op, exp_op);
            check("unit_a", unit_a, exp_a);
            check("unit_b", unit_b, exp_b);
         end
         check("mux_en", mux_en, dl_en[L-1]);
         if (!res_valid) check("empty_head", {res_err, res_data}, 0);
         if (sb.size() == 0) check("valid_no_credit", res_valid, 0);
         if (dut.fifo_wr) check("wr_full", dut.fifo_count_reg == D, 0);
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               check("pop_empty_sb", 1, 0);
            end else begin
               e = sb.pop_front();
               check("res_data", res_data, e.data);
               check("res_err", res_err, e.err);
               if (chk_lat) check("latency", cyc - e.cyc, L + 3);
               popped.push_back({res_err, res_data});
            end
         end
         ld_prev = in_valid && in_ready;
         if (ld_prev) begin
            e.data = (unit_of(in_op) == 3'b000) ? '0 : alu_ref(in_op, in_a, in_b);
            e.err  = (unit_of(in_op) == 3'b000);
            e.cyc  = cyc;
            sb.push_back(e);
            n_acc++;
            exp_en = unit_of(in_op);
            exp_op = in_op;
            exp_a  = in_a;
            exp_b  = in_b;
            $display("t=%0t accept op=%0d a=0x%0h b=0x%0h exp=0x%0h err=%0b", $time, in_op, in_a, in_b, e.data, e.err);
         end else begin
            exp_en = 3'b000;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      for (int t = 0; t < 100 && !done; t++) begin
         done = in_ready;
         step();
      end
      if (!done) check("issue_timeout", 1, 0);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      res_ready = 1'b1;
      for (int t = 0; t < 60 && sb.size() != 0; t++) step();
      check("drain", sb.size(), 0);
      repeat (2) step();
   endtask

   initial begin
      int p0;
      int a0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_ctl", {in_ready, unit_en, mux_en, res_valid, res_err}, 0);
      check("rst_data", {unit_op, unit_a, unit_b, res_data}, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Back-to-back mixed issue.
      res_ready = 1'b1;
      chk_lat   = 1'b1;
      p0 = popped.size();
      issue(4'd0, 16'd3, 16'd4);
      issue(4'd4, 16'h00F0, 16'h0FF0);
      issue(4'd7, 16'h8000, 16'd4);
      drain();
      check("b2b_count", popped.size() - p0, 3);
      if (popped.size() >= p0 + 3) begin
         check("b2b_r0", popped[p0],   {1'b0, 16'd7});
         check("b2b_r1", popped[p0+1], {1'b0, 16'h0F00});
         check("b2b_r2", popped[p0+2], {1'b0, 16'h0800});
      end

      // Illegal opcode between legal ones.
      p0 = popped.size();
      issue(4'd0, 16'd1, 16'd2);
      issue(4'd12, 16'd5, 16'd6);
      issue(4'd4, 16'h1234, 16'h00FF);
      drain();
      chk_lat = 1'b0;
      check("ill_count", popped.size() - p0, 3);
      if (popped.size() >= p0 + 3) begin
         check("ill_r0", popped[p0],   {1'b0, 16'd3});
         check("ill_r1", popped[p0+1], {1'b1, 16'd0});
         check("ill_r2", popped[p0+2], {1'b0, 16'h12CB});
      end

      // Backpressure: only FIFO_DEPTH ops accepted.
      res_ready = 1'b0;
      a0 = n_acc;
      in_valid = 1'b1;
      in_op    = 4'd0;
      for (int i = 0; i < 6; i++) begin
         in_a = W'(i);
         in_b = W'(100);
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();
      check("bp_accepted", n_acc - a0, D);
      check("bp_ready_low", in_ready, 0);
      p0 = popped.size();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("bp_one_pop", popped.size() - p0, 1);
      check("bp_ready_next", in_ready, 1);
      drain();

      // Simultaneous accept and pop at one credit below full.
      res_ready = 1'b0;
      for (int i = 0; i < D - 1; i++) issue(4'd1, W'(50 + i), W'(i));
      repeat (6) step();
      for (int r = 0; r < 3; r++) begin
         check("sim_pre_os", dut.outstanding_reg, D - 1);
         in_valid  = 1'b1;
         in_op     = 4'd3;
         in_a      = W'(16'h0100 << r);
         in_b      = W'(r);
         res_ready = 1'b1;
         step();
         in_valid  = 1'b0;
         res_ready = 1'b0;
         check("sim_os_const", dut.outstanding_reg, D - 1);
         repeat (5) step();
      end
      drain();

      // Reset with ops queued and in flight.
      res_ready = 1'b0;
      issue(4'd2, 16'hFFFF, 16'h0F0F);
      issue(4'd6, 16'h0001, 16'd3);
      repeat (6) step();
      issue(4'd5, 16'h00FF, 16'd0);
      issue(4'd8, 16'h8000, 16'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ctl", {in_ready, unit_en, mux_en, res_valid, res_err}, 0);
      check("mid_rst_data", {unit_op, unit_a, unit_b, res_data}, 0);
      step();
      step();
      rst_n = 1'b1;
      check("rel_ready_first", in_ready, 0);
      step();
      check("rel_ready_up", in_ready, 1);
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("rel_no_valid", res_valid, 0);
         step();
      end
      issue(4'd1, 16'd10, 16'd3);
      drain();

      // Random traffic with stalls, wrapping the FIFO pointers many times.
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_op     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         in_a      = W'($urandom);
         in_b      = W'($urandom);
         res_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      in_valid = 1'b0;
      drain();
      check("rand_ops_min", n_acc > 40, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
